lfsr_rr_server: RTL and testbench

//   Owns an 8-bit Fibonacci LFSR and shares its output among N requesters.

---
 rtl/lfsr_rr_server_if.sv | 36 +++
 rtl/lfsr_rr_server.sv | 152 +++++++++++++++
 tb/tb_lfsr_rr_server.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rr_server_if.sv
// Bus between the random-byte server and its consumers: seeding,
// per-requester request/grant, the shared random byte and transfer count.
`timescale 1ns/1ps
interface lfsr_rr_server_if #(
  parameter int N = 4
) ();
  logic           seed_valid;
  logic [7:0]     seed;
  logic           ready;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [7:0]     rnd_data;
  logic [15:0]    grant_cnt;

  // Consumer side: drives seed and requests, observes grants and data.
  modport master (
    output seed_valid,
    output seed,
    output req,
    input  ready,
    input  gnt,
    input  rnd_data,
    input  grant_cnt
  );

  // Server side.
  modport slave (
    input  seed_valid,
    input  seed,
    input  req,
    output ready,
    output gnt,
    output rnd_data,
    output grant_cnt
  );
endinterface

// File: rtl/lfsr_rr_server.sv
// Round-robin server for an 8-bit Fibonacci LFSR.
// The LFSR is seeded, warmed up for WARMUP steps and then hands one byte per
// accepted request to N requesters. Grants are combinational (zero-cycle
// handshake); the LFSR steps only when a transfer actually happens.
`timescale 1ns/1ps
module lfsr_rr_server #(
  parameter int N      = 4,
  parameter int WARMUP = 4
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_rr_server_if.slave    bus
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  // Last warm-up count before switching to SERVE; unused when WARMUP is 0
  // because seeding then jumps straight to SERVE.
  localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  // Highest requester index, used for the wrap of the round-robin pointer.
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [7:0]         lfsr_q,      lfsr_d;
  logic [7:0]         warm_cnt_q,  warm_cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;

  logic               serving;
  logic [N-1:0]       req_eff;
  logic [N-1:0]       hi_mask;
  logic [N-1:0]       req_hi;
  logic [N-1:0]       cand;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [N-1:0]       gnt_vec;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [7:0]         lfsr_step;
  logic [7:0]         seed_safe;

  // One LFSR step: shift right, feedback of taps 4,3,2,0 into bit 7.
  assign lfsr_step = {lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0], lfsr_q[7:1]};

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  assign seed_safe = (bus.seed == 8'h00) ? 8'h01 : bus.seed;

  // Grants are only offered in SERVE, and never in a cycle that reseeds.
  assign serving = (state_q == SERVE) && !bus.seed_valid;
  assign req_eff = serving ? bus.req : '0;

  // Mask of indices at or above the round-robin pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (PTR_W'(gi) >= rr_ptr_q);
  end

  assign req_hi = req_eff & hi_mask;

  // Search from rr_ptr upward first; if nothing is there, wrap to index 0.
  assign cand = (|req_hi) ? req_hi : req_eff;

  // Pick the lowest set candidate (loop runs high to low so the lowest wins).
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_idx = PTR_W'(i);
        pick_any = 1'b1;
      end
    end
  end

  // Build the one-hot grant from the picked index.
  always_comb begin
    gnt_vec = '0;
    if (pick_any) begin
      gnt_vec[pick_idx] = 1'b1;
    end
  end

  // The pointer moves just past the requester that was served.
  assign ptr_nxt = (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;

  // Next-state logic: seeding, warm-up stepping and per-transfer updates.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    warm_cnt_d  = warm_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_cnt_d = grant_cnt_q;

    if (bus.seed_valid) begin
      // Seeding is honoured in every state and restarts the warm-up.
      lfsr_d     = seed_safe;
      warm_cnt_d = 8'd0;
      state_d    = (WARMUP == 0) ? SERVE : WARM;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WARM: begin
          lfsr_d     = lfsr_step;
          warm_cnt_d = warm_cnt_q + 8'd1;
          if (warm_cnt_q == WARM_LAST) begin
            state_d = SERVE;
          end
        end
        SERVE: begin
          if (pick_any) begin
            lfsr_d      = lfsr_step;
            rr_ptr_d    = ptr_nxt;
            grant_cnt_d = grant_cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register; reset overrides seeding, warm-up and serving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= 8'h01;
      warm_cnt_q  <= 8'd0;
      rr_ptr_q    <= '0;
      grant_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      warm_cnt_q  <= warm_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.ready     = (state_q == SERVE);
  assign bus.gnt       = gnt_vec;
  assign bus.rnd_data  = lfsr_q;
  assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_lfsr_rr_server.sv
// Directed bench for lfsr_rr_server (N=4, WARMUP=4).
`timescale 1ns/1ps
module tb_lfsr_rr_server;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] model;

  lfsr_rr_server_if #(.N(4)) bus ();

  lfsr_rr_server #(.N(4), .WARMUP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR step.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  // Advance past the next rising edge and let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %0b exp 0", bus.ready);
    end
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt);
    end
    checks++;
    if (bus.rnd_data !== 8'h01) begin
      errors++; $display("FAIL reset_rnd got %h exp 01", bus.rnd_data);
    end
    checks++;
    if (bus.grant_cnt !== 16'h0000) begin
      errors++; $display("FAIL reset_cnt got %h exp 0000", bus.grant_cnt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL idle_gnt got %b exp 0000", bus.gnt);
    end
    bus.req = 4'b0000;
    $display("test_reset done");
  endtask

  task automatic test_warmup();
    logic [7:0] warm_exp [4];
    warm_exp = '{8'h80, 8'h40, 8'h20, 8'h10};
    bus.seed_valid = 1'b1;
    bus.seed = 8'h01;
    tick();
    bus.seed_valid = 1'b0;
    #1;
    checks++;
    if (bus.rnd_data !== 8'h01 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL seed_load got rnd=%h rdy=%0b exp rnd=01 rdy=0", bus.rnd_data, bus.ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.rnd_data !== warm_exp[i] || bus.ready !== (i == 3)) begin
        errors++;
        $display("FAIL warm_step%0d got rnd=%h rdy=%0b exp rnd=%h rdy=%0b",
                 i, bus.rnd_data, bus.ready, warm_exp[i], (i == 3));
      end
    end
    bus.req = 4'b0001;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.rnd_data !== 8'h10) begin
      errors++; $display("FAIL serve_first got gnt=%b rnd=%h exp gnt=0001 rnd=10", bus.gnt, bus.rnd_data);
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0001 || bus.rnd_data !== 8'h88) begin
      errors++; $display("FAIL serve_second got gnt=%b rnd=%h exp gnt=0001 rnd=88", bus.gnt, bus.rnd_data);
    end
    tick();
    bus.req = 4'b0000;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000 || bus.rnd_data !== 8'hC4 || bus.grant_cnt !== 16'd2) begin
      errors++;
      $display("FAIL serve_idle got gnt=%b rnd=%h cnt=%0d exp gnt=0000 rnd=c4 cnt=2",
               bus.gnt, bus.rnd_data, bus.grant_cnt);
    end
    tick();
    checks++;
    if (bus.rnd_data !== 8'hC4) begin
      errors++; $display("FAIL serve_hold got rnd=%h exp c4", bus.rnd_data);
    end
    model = 8'hC4;
    $display("test_warmup done");
  endtask

  // rr_ptr is 1 here: exercises skipping, wrap to 0, and a high index.
  task automatic test_rr_wrap();
    logic [3:0] req_v [3];
    logic [3:0] gnt_v [3];
    req_v = '{4'b0101, 4'b0101, 4'b1000};
    gnt_v = '{4'b0100, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      bus.req = req_v[i];
      #1;
      checks++;
      if (bus.gnt !== gnt_v[i] || bus.rnd_data !== model) begin
        errors++;
        $display("FAIL rr_wrap%0d got gnt=%b rnd=%h exp gnt=%b rnd=%h",
                 i, bus.gnt, bus.rnd_data, gnt_v[i], model);
      end
      tick();
      model = ref_step(model);
    end
    bus.req = 4'b0000;
    $display("test_rr_wrap done");
  endtask

  // rr_ptr is 0 here after granting index 3.
  task automatic test_round_robin();
    logic [3:0]  gnt_v [5];
    logic [15:0] cnt0;
    gnt_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cnt0 = bus.grant_cnt;
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.gnt !== gnt_v[i] || bus.rnd_data !== model) begin
        errors++;
        $display("FAIL rr_all%0d got gnt=%b rnd=%h exp gnt=%b rnd=%h",
                 i, bus.gnt, bus.rnd_data, gnt_v[i], model);
      end
      tick();
      model = ref_step(model);
    end
    bus.req = 4'b0000;
    #1;
    checks++;
    if (bus.grant_cnt !== cnt0 + 16'd5) begin
      errors++; $display("FAIL rr_count got %0d exp %0d", bus.grant_cnt, cnt0 + 16'd5);
    end
    $display("test_round_robin done");
  endtask

  task automatic test_seed_zero_reseed();
    logic [15:0] cnt0;
    cnt0 = bus.grant_cnt;
    bus.req = 4'b1111;
    bus.seed_valid = 1'b1;
    bus.seed = 8'h00;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL reseed_gnt got %b exp 0000", bus.gnt);
    end
    tick();
    bus.seed_valid = 1'b0;
    #1;
    checks++;
    if (bus.rnd_data !== 8'h01 || bus.ready !== 1'b0 || bus.grant_cnt !== cnt0) begin
      errors++;
      $display("FAIL seed_zero got rnd=%h rdy=%0b cnt=%0d exp rnd=01 rdy=0 cnt=%0d",
               bus.rnd_data, bus.ready, bus.grant_cnt, cnt0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0000) begin
        errors++; $display("FAIL warm_gnt%0d got %b exp 0000", i, bus.gnt);
      end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.ready !== 1'b1 || bus.rnd_data !== 8'h10) begin
      errors++; $display("FAIL rewarm got rdy=%0b rnd=%h exp rdy=1 rnd=10", bus.ready, bus.rnd_data);
    end
    $display("test_seed_zero_reseed done");
  endtask

  task automatic test_reset_mid_warm();
    bus.seed_valid = 1'b1;
    bus.seed = 8'h5A;
    tick();
    bus.seed_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.rnd_data !== 8'h01 || bus.grant_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_warm_rst got rdy=%0b rnd=%h cnt=%0d exp rdy=0 rnd=01 cnt=0",
               bus.ready, bus.rnd_data, bus.grant_cnt);
    end
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0000 || bus.rnd_data !== 8'h01 || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_req%0d got gnt=%b rnd=%h rdy=%0b exp gnt=0000 rnd=01 rdy=0",
                 i, bus.gnt, bus.rnd_data, bus.ready);
      end
    end
    bus.req = 4'b0000;
    $display("test_reset_mid_warm done");
  endtask

  task automatic test_grant_cnt_wrap();
    int         mism;
    int         repeats;
    int         dut_period;
    int         ref_period;
    logic [7:0] prev;
    logic [7:0] s;
    mism = 0; repeats = 0; dut_period = 0; ref_period = 0; prev = 8'h00;
    s = ref_step(8'h10);
    for (int k = 1; k <= 256; k++) begin
      if (ref_period == 0 && s == 8'h10) ref_period = k;
      s = ref_step(s);
    end
    bus.seed_valid = 1'b1;
    bus.seed = 8'h01;
    tick();
    bus.seed_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    model = 8'h10;
    bus.req = 4'b0001;
    #1;
    for (int i = 0; i < 65535; i++) begin
      if (bus.rnd_data !== model) mism++;
      if (i > 0 && bus.rnd_data === prev) repeats++;
      if (i > 0 && dut_period == 0 && bus.rnd_data === 8'h10) dut_period = i;
      prev = bus.rnd_data;
      tick();
      model = ref_step(model);
    end
    checks++;
    if (mism != 0) begin
      errors++; $display("FAIL long_seq got %0d mismatching bytes exp 0", mism);
    end
    checks++;
    if (repeats != 0) begin
      errors++; $display("FAIL long_repeat got %0d repeated bytes exp 0", repeats);
    end
    checks++;
    if (dut_period != ref_period) begin
      errors++; $display("FAIL lfsr_period got %0d exp %0d", dut_period, ref_period);
    end
    checks++;
    if (bus.grant_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_ffff got %h exp ffff", bus.grant_cnt);
    end
    tick();
    bus.req = 4'b0000;
    #1;
    checks++;
    if (bus.grant_cnt !== 16'h0000) begin
      errors++; $display("FAIL cnt_wrap got %h exp 0000", bus.grant_cnt);
    end
    $display("test_grant_cnt_wrap done period=%0d", ref_period);
  endtask

  // Safety net against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    model = 8'h01;
    rst = 1'b1;
    bus.seed_valid = 1'b0;
    bus.seed = 8'h00;
    bus.req = 4'b0000;
    test_reset();
    test_warmup();
    test_rr_wrap();
    test_round_robin();
    test_seed_zero_reseed();
    test_reset_mid_warm();
    test_grant_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
